word_game_ctrl: RTL and testbench
=================================

WORD_GAME_CTRL -- requirements
Module: word_game_ctrl

Interface
REQ-001 SHALL have parameters: NUM_MODES, default 3, number of word-length modes; SCORE_W, default 7, score width; IDX_W, default 3, letter-index width; PID_W, default 3, player-ID width.
REQ-002 clk  in  1  single clock; all logic on posedge clk.
REQ-003 rst  in  1  reset, synchronous and active-low.
REQ-004 logOn, pwdPls, startPls, loadPls, isCorrect, timeOut  in  1 each  one-cycle-wide user/status pulses; isCorrect and timeOut are levels.
REQ-005 pIDin  in  PID_W  current player ID; isGuestIn  in  1  guest flag.
REQ-006 indIn1, indIn2  in  IDX_W  swap letter indices.
REQ-007 Mux_Ctrl, logOut, timerEn, timerReconfig, scramPls, flipPls, newRecord  out  1 each.
REQ-008 controlSig  out  3  display page: 0 idle, 1 setup, 2 play, 3 game over, 4 top score, 5 top-score holder.
REQ-009 mode  out  clog2(NUM_MODES)  selected mode; modeDisp  out  4  mode+4.
REQ-010 score, topScore  out  SCORE_W; pIDout, topPid  out  PID_W; isGuestOut  out  1.
REQ-011 indOut1, indOut2  out  IDX_W  latched swap indices.

Function
REQ-012 FSM states: INIT, SETUP, GETWORD, SWAP, CORRECT, GAMEOVER, LOGOUT, TOPSCORE; state register one-hot or binary, unused codes go to INIT.
REQ-013 INIT: controlSig=0, all pulses 0, mode=0; logOn -> SETUP with Mux_Ctrl=1, timerEn=1.
REQ-014 SETUP: score=0, controlSig=1; priority pwdPls > loadPls > startPls.
REQ-015 SETUP pwdPls -> LOGOUT, logOut=1 for exactly one cycle.
REQ-016 SETUP loadPls: mode increments; at mode==NUM_MODES-1, mode wraps to 0 and state -> TOPSCORE, flag cleared.
REQ-017 SETUP startPls -> GETWORD, controlSig=2, timerReconfig=1 for exactly one cycle.
REQ-018 GETWORD priority startPls (-> SETUP) > timeOut (-> GAMEOVER) > pwdPls (-> SWAP, scramPls=1 one cycle).
REQ-019 SWAP: indOut1<=indIn1, indOut2<=indIn2 every cycle; priority startPls > timeOut > isCorrect (-> CORRECT) > loadPls (flipPls=1 one cycle, stay).
REQ-020 CORRECT: score saturates at 2^SCORE_W-1, no wrap; -> GETWORD next cycle.
REQ-021 GAMEOVER: controlSig=3, pIDout<=pIDin, isGuestOut<=isGuestIn; on entry cycle compare score with best[mode].
REQ-022 Record update: if score>best[mode] and isGuestIn=0, best[mode]<=score, bestPid[mode]<=pIDin, newRecord=1 one cycle; tie or guest: no update, newRecord=0.
REQ-023 GAMEOVER startPls -> SETUP, mode=0.
REQ-024 LOGOUT: timerEn=0, logOut=0, Mux_Ctrl=0 -> INIT next cycle; best table retained.
REQ-025 TOPSCORE: topScore/topPid show best[mode] (browse mode); startPls toggles flag; controlSig=4 flag=0, 5 flag=1; loadPls advances browse mode, wrap at NUM_MODES-1 -> SETUP with mode=0.
REQ-026 Every output pulse SHALL be high exactly one cycle per triggering event; simultaneous inputs resolved only by the listed priorities.

Reset
REQ-027 rst=0 at any clk edge, any state: state INIT, all outputs 0, mode 0, score 0, flag 0, best table and bestPid all 0.
REQ-028 Reset mid-game discards current score without record update.

Structure
REQ-029 Shared package holds state encoding, controlSig page constants, default parameter values.
REQ-030 One sub-module score_table: NUM_MODES x (SCORE_W+PID_W) register file, one write port, one read port addressed by mode, synchronous reset clears.

Verification
REQ-031 Reset in SWAP with score=5 -> next cycle INIT, score=0, controlSig=0, best[*]=0.
REQ-032 logOn, startPls, pwdPls, isCorrect x3, timeOut -> score=3, GAMEOVER, controlSig=3, newRecord=1, best[0]=3.
REQ-033 SCORE_W=3, 9 correct words -> score holds 7.
REQ-034 Guest (isGuestIn=1) scores 6 over best 2 -> best stays 2, newRecord=0.
REQ-035 SETUP loadPls x3 with NUM_MODES=3 -> mode 1,2, then TOPSCORE mode 0; startPls -> controlSig 5; loadPls x3 -> SETUP.
REQ-036 SWAP with timeOut, isCorrect, loadPls same cycle -> GAMEOVER, no flipPls, no score increment.

Source files
------------

// File: rtl/word_game_ctrl_pkg.sv
// Shared definitions for the word game controller.
// Holds the controller state encoding, the display page codes driven on
// controlSig, and the default values of the top-level parameters.
package word_game_ctrl_pkg;

   localparam int DEF_NUM_MODES = 3;
   localparam int DEF_SCORE_W   = 7;
   localparam int DEF_IDX_W     = 3;
   localparam int DEF_PID_W     = 3;

   // Binary state encoding; all eight codes are used.
   typedef enum logic [2:0] {
      ST_INIT     = 3'd0,
      ST_SETUP    = 3'd1,
      ST_GETWORD  = 3'd2,
      ST_SWAP     = 3'd3,
      ST_CORRECT  = 3'd4,
      ST_GAMEOVER = 3'd5,
      ST_LOGOUT   = 3'd6,
      ST_TOPSCORE = 3'd7
   } state_t;

   // Display pages shown on controlSig.
   localparam logic [2:0] PAGE_IDLE   = 3'd0;
   localparam logic [2:0] PAGE_SETUP  = 3'd1;
   localparam logic [2:0] PAGE_PLAY   = 3'd2;
   localparam logic [2:0] PAGE_OVER   = 3'd3;
   localparam logic [2:0] PAGE_TOP    = 3'd4;
   localparam logic [2:0] PAGE_HOLDER = 3'd5;

endpackage

// File: rtl/score_table.sv
// Best-score register file: one entry per word-length mode, each entry
// holding the best score and the ID of the player who set it.
// Ports:
//   clk, rst          clock, synchronous active-low reset (clears every entry)
//   we, waddr         write enable and entry index
//   wscore, wpid      data written on we
//   raddr             read index (combinational read)
//   rscore, rpid      contents of entry raddr (0 for an index past the table)
module score_table #(
   parameter int NUM_MODES = 3,
   parameter int SCORE_W   = 7,
   parameter int PID_W     = 3,
   parameter int MODE_W    = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [MODE_W-1:0]  waddr,
   input  logic [SCORE_W-1:0] wscore,
   input  logic [PID_W-1:0]   wpid,
   input  logic [MODE_W-1:0]  raddr,
   output logic [SCORE_W-1:0] rscore,
   output logic [PID_W-1:0]   rpid
);

   logic [SCORE_W-1:0] score_mem [NUM_MODES];
   logic [PID_W-1:0]   pid_mem   [NUM_MODES];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_MODES; i++) begin
            score_mem[i] <= '0;
            pid_mem[i]   <= '0;
         end
      end else if (we && (int'(waddr) < NUM_MODES)) begin
         score_mem[waddr] <= wscore;
         pid_mem[waddr]   <= wpid;
      end
   end

   always_comb begin
      rscore = '0;
      rpid   = '0;
      if (int'(raddr) < NUM_MODES) begin
         rscore = score_mem[raddr];
         rpid   = pid_mem[raddr];
      end
   end

endmodule

// File: rtl/word_game_ctrl.sv
// Word game controller: login/logout, mode selection, the guess/swap loop,
// scoring with saturation, per-mode best-score records and a top-score
// browser.
// Handshake: there are no valid/ready channels; every *Pls input is a
// one-cycle event sampled on posedge clk, isCorrect/timeOut are levels
// sampled on posedge clk, and every pulse output is a registered one-cycle
// strobe appearing in the cycle after the event that caused it.
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   logOn..timeOut            user/status events (see handshake note)
//   pIDin, isGuestIn          current player ID and guest flag
//   indIn1, indIn2            letter indices to swap
//   Mux_Ctrl, timerEn         levels, high from login until logout completes
//   logOut, timerReconfig,
//   scramPls, flipPls,
//   newRecord                 one-cycle strobes
//   controlSig                display page (idle/setup/play/over/top/holder)
//   mode, modeDisp            selected mode, and mode+4 for the display
//   score                     current game score
//   topScore, topPid          best entry for the current mode
//   pIDout, isGuestOut        player info latched while in game over
//   indOut1, indOut2          swap indices latched while swapping
//   state_dbg                 current controller state
module word_game_ctrl
   import word_game_ctrl_pkg::*;
#(
   parameter int NUM_MODES = DEF_NUM_MODES,
   parameter int SCORE_W   = DEF_SCORE_W,
   parameter int IDX_W     = DEF_IDX_W,
   parameter int PID_W     = DEF_PID_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         logOn,
   input  logic                         pwdPls,
   input  logic                         startPls,
   input  logic                         loadPls,
   input  logic                         isCorrect,
   input  logic                         timeOut,
   input  logic [PID_W-1:0]             pIDin,
   input  logic                         isGuestIn,
   input  logic [IDX_W-1:0]             indIn1,
   input  logic [IDX_W-1:0]             indIn2,
   output logic                         Mux_Ctrl,
   output logic                         logOut,
   output logic                         timerEn,
   output logic                         timerReconfig,
   output logic                         scramPls,
   output logic                         flipPls,
   output logic                         newRecord,
   output logic [2:0]                   controlSig,
   output logic [$clog2(NUM_MODES)-1:0] mode,
   output logic [3:0]                   modeDisp,
   output logic [SCORE_W-1:0]           score,
   output logic [SCORE_W-1:0]           topScore,
   output logic [PID_W-1:0]             pIDout,
   output logic [PID_W-1:0]             topPid,
   output logic                         isGuestOut,
   output logic [IDX_W-1:0]             indOut1,
   output logic [IDX_W-1:0]             indOut2,
   output logic [2:0]                   state_dbg
);

   localparam int MODE_W = $clog2(NUM_MODES);
   localparam logic [MODE_W-1:0]  MODE_LAST = MODE_W'(NUM_MODES - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   state_t             state_q, state_d;
   logic [MODE_W-1:0]  mode_q, mode_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic               flag_q, flag_d;      // top-score page: 0 score, 1 holder
   logic               entry_q, entry_d;    // first cycle of game over
   logic [IDX_W-1:0]   ind1_q, ind1_d, ind2_q, ind2_d;
   logic [PID_W-1:0]   pid_q, pid_d;
   logic               guest_q, guest_d;
   logic               mux_q, mux_d, ten_q, ten_d;
   logic               log_q, log_d, reconf_q, reconf_d;
   logic               scram_q, scram_d, flip_q, flip_d, rec_q, rec_d;

   logic               tbl_we;
   logic [SCORE_W-1:0] tbl_score;
   logic [PID_W-1:0]   tbl_pid;

   score_table #(
      .NUM_MODES (NUM_MODES),
      .SCORE_W   (SCORE_W),
      .PID_W     (PID_W),
      .MODE_W    (MODE_W)
   ) u_score_table (
      .clk    (clk),
      .rst    (rst),
      .we     (tbl_we),
      .waddr  (mode_q),
      .wscore (score_q),
      .wpid   (pIDin),
      .raddr  (mode_q),
      .rscore (tbl_score),
      .rpid   (tbl_pid)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_INIT;
         mode_q   <= '0;
         score_q  <= '0;
         flag_q   <= 1'b0;
         entry_q  <= 1'b0;
         ind1_q   <= '0;
         ind2_q   <= '0;
         pid_q    <= '0;
         guest_q  <= 1'b0;
         mux_q    <= 1'b0;
         ten_q    <= 1'b0;
         log_q    <= 1'b0;
         reconf_q <= 1'b0;
         scram_q  <= 1'b0;
         flip_q   <= 1'b0;
         rec_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         score_q  <= score_d;
         flag_q   <= flag_d;
         entry_q  <= entry_d;
         ind1_q   <= ind1_d;
         ind2_q   <= ind2_d;
         pid_q    <= pid_d;
         guest_q  <= guest_d;
         mux_q    <= mux_d;
         ten_q    <= ten_d;
         log_q    <= log_d;
         reconf_q <= reconf_d;
         scram_q  <= scram_d;
         flip_q   <= flip_d;
         rec_q    <= rec_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      score_d  = score_q;
      flag_d   = flag_q;
      entry_d  = 1'b0;
      ind1_d   = ind1_q;
      ind2_d   = ind2_q;
      pid_d    = pid_q;
      guest_d  = guest_q;
      mux_d    = mux_q;
      ten_d    = ten_q;
      log_d    = 1'b0;
      reconf_d = 1'b0;
      scram_d  = 1'b0;
      flip_d   = 1'b0;
      rec_d    = 1'b0;
      tbl_we   = 1'b0;

      case (state_q)
         ST_INIT: begin
            mode_d  = '0;
            score_d = '0;
            flag_d  = 1'b0;
            if (logOn) begin
               state_d = ST_SETUP;
               mux_d   = 1'b1;
               ten_d   = 1'b1;
            end
         end
         ST_SETUP: begin
            if (pwdPls) begin
               state_d = ST_LOGOUT;
               log_d   = 1'b1;
            end else if (loadPls) begin
               if (mode_q == MODE_LAST) begin
                  mode_d  = '0;
                  flag_d  = 1'b0;
                  state_d = ST_TOPSCORE;
               end else begin
                  mode_d = MODE_W'(mode_q + 1'b1);
               end
            end else if (startPls) begin
               state_d  = ST_GETWORD;
               reconf_d = 1'b1;
            end
         end
         ST_GETWORD: begin
            if (startPls) begin
               state_d = ST_SETUP;
            end else if (timeOut) begin
               state_d = ST_GAMEOVER;
               entry_d = 1'b1;
            end else if (pwdPls) begin
               state_d = ST_SWAP;
               scram_d = 1'b1;
            end
         end
         ST_SWAP: begin
            ind1_d = indIn1;
            ind2_d = indIn2;
            if (startPls) begin
               state_d = ST_SETUP;
            end else if (timeOut) begin
               state_d = ST_GAMEOVER;
               entry_d = 1'b1;
            end else if (isCorrect) begin
               state_d = ST_CORRECT;
            end else if (loadPls) begin
               flip_d = 1'b1;
            end
         end
         ST_CORRECT: begin
            if (score_q != SCORE_MAX) score_d = score_q + 1'b1;
            state_d = ST_GETWORD;
         end
         ST_GAMEOVER: begin
            pid_d   = pIDin;
            guest_d = isGuestIn;
            // The record decision is made once, in the first game-over cycle;
            // a tie never replaces the existing holder.
            if (entry_q && !isGuestIn && (score_q > tbl_score)) begin
               tbl_we = 1'b1;
               rec_d  = 1'b1;
            end
            if (startPls) begin
               state_d = ST_SETUP;
               mode_d  = '0;
            end
         end
         ST_LOGOUT: begin
            mux_d   = 1'b0;
            ten_d   = 1'b0;
            state_d = ST_INIT;
         end
         ST_TOPSCORE: begin
            if (startPls) begin
               flag_d = ~flag_q;
            end else if (loadPls) begin
               if (mode_q == MODE_LAST) begin
                  mode_d  = '0;
                  flag_d  = 1'b0;
                  state_d = ST_SETUP;
               end else begin
                  mode_d = MODE_W'(mode_q + 1'b1);
               end
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase

      // The setup page always starts from a zero score, whichever way it is entered.
      if (state_d == ST_SETUP) score_d = '0;
   end

   always_comb begin
      controlSig = PAGE_IDLE;
      case (state_q)
         ST_SETUP:    controlSig = PAGE_SETUP;
         ST_GETWORD,
         ST_SWAP,
         ST_CORRECT:  controlSig = PAGE_PLAY;
         ST_GAMEOVER: controlSig = PAGE_OVER;
         ST_TOPSCORE: controlSig = flag_q ? PAGE_HOLDER : PAGE_TOP;
         default:     controlSig = PAGE_IDLE;
      endcase
   end

   assign Mux_Ctrl      = mux_q;
   assign timerEn       = ten_q;
   assign logOut        = log_q;
   assign timerReconfig = reconf_q;
   assign scramPls      = scram_q;
   assign flipPls       = flip_q;
   assign newRecord     = rec_q;
   assign mode          = mode_q;
   assign modeDisp      = 4'(mode_q) + 4'd4;
   assign score         = score_q;
   assign topScore      = tbl_score;
   assign topPid        = tbl_pid;
   assign pIDout        = pid_q;
   assign isGuestOut    = guest_q;
   assign indOut1       = ind1_q;
   assign indOut2       = ind2_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_word_game_ctrl.sv
// Bench for word_game_ctrl: directed scenarios with literal expectations,
// followed by randomized stimulus, all checked every cycle against a
// behavioural model of the game rules. A second instance with a 3-bit
// score shares the stimulus to exercise score saturation.
module tb_word_game_ctrl;
   import word_game_ctrl_pkg::*;

   localparam int NM = 3;
   localparam logic [5:0] P_LOGON = 6'b000001;
   localparam logic [5:0] P_PWD   = 6'b000010;
   localparam logic [5:0] P_START = 6'b000100;
   localparam logic [5:0] P_LOAD  = 6'b001000;
   localparam logic [5:0] P_CORR  = 6'b010000;
   localparam logic [5:0] P_TOUT  = 6'b100000;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic       logOn = 0, pwdPls = 0, startPls = 0, loadPls = 0, isCorrect = 0, timeOut = 0;
   logic [2:0] pIDin = 0;
   logic       isGuestIn = 0;
   logic [2:0] indIn1 = 0, indIn2 = 0;

   logic       Mux_Ctrl, logOut, timerEn, timerReconfig, scramPls, flipPls, newRecord;
   logic [2:0] controlSig, state_dbg;
   logic [1:0] mode;
   logic [3:0] modeDisp;
   logic [6:0] score, topScore;
   logic [2:0] pIDout, topPid, indOut1, indOut2;
   logic       isGuestOut;

   logic       b_mux, b_log, b_ten, b_rec, b_scr, b_flip, b_new, b_guest;
   logic [2:0] b_cs, b_st, b_pid, b_tpid, b_i1, b_i2;
   logic [1:0] b_mode;
   logic [3:0] b_md;
   logic [2:0] b_score, b_top;

   word_game_ctrl dut (
      .clk(clk), .rst(rst), .logOn(logOn), .pwdPls(pwdPls), .startPls(startPls),
      .loadPls(loadPls), .isCorrect(isCorrect), .timeOut(timeOut), .pIDin(pIDin),
      .isGuestIn(isGuestIn), .indIn1(indIn1), .indIn2(indIn2), .Mux_Ctrl(Mux_Ctrl),
      .logOut(logOut), .timerEn(timerEn), .timerReconfig(timerReconfig),
      .scramPls(scramPls), .flipPls(flipPls), .newRecord(newRecord),
      .controlSig(controlSig), .mode(mode), .modeDisp(modeDisp), .score(score),
      .topScore(topScore), .pIDout(pIDout), .topPid(topPid), .isGuestOut(isGuestOut),
      .indOut1(indOut1), .indOut2(indOut2), .state_dbg(state_dbg)
   );

   word_game_ctrl #(.SCORE_W(3)) dut_w3 (
      .clk(clk), .rst(rst), .logOn(logOn), .pwdPls(pwdPls), .startPls(startPls),
      .loadPls(loadPls), .isCorrect(isCorrect), .timeOut(timeOut), .pIDin(pIDin),
      .isGuestIn(isGuestIn), .indIn1(indIn1), .indIn2(indIn2), .Mux_Ctrl(b_mux),
      .logOut(b_log), .timerEn(b_ten), .timerReconfig(b_rec),
      .scramPls(b_scr), .flipPls(b_flip), .newRecord(b_new),
      .controlSig(b_cs), .mode(b_mode), .modeDisp(b_md), .score(b_score),
      .topScore(b_top), .pIDout(b_pid), .topPid(b_tpid), .isGuestOut(b_guest),
      .indOut1(b_i1), .indOut2(b_i2), .state_dbg(b_st)
   );

   // ---------------- scoreboard counters ----------------
   int n_total = 0;
   int n_pass  = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Score is tracked as an unbounded count of correct words; each width
   // sees it clipped to its own maximum.
   state_t m_st = ST_INIT;
   int     m_mode = 0, m_cnt = 0;
   logic   m_flag = 0, m_first = 0;
   int     m_best [NM];
   int     m_bpid [NM];
   logic   m_mux = 0, m_ten = 0;
   logic   e_log = 0, e_reconf = 0, e_scram = 0, e_flip = 0, e_rec = 0;
   int     m_ind1 = 0, m_ind2 = 0, m_pid = 0;
   logic   m_guest = 0;

   function automatic int clip(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic int page(input state_t s, input logic f);
      case (s)
         ST_SETUP:                       return 1;
         ST_GETWORD, ST_SWAP, ST_CORRECT: return 2;
         ST_GAMEOVER:                    return 3;
         ST_TOPSCORE:                    return f ? 5 : 4;
         default:                        return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_st = ST_INIT; m_mode = 0; m_cnt = 0; m_flag = 0; m_first = 0;
      m_mux = 0; m_ten = 0;
      e_log = 0; e_reconf = 0; e_scram = 0; e_flip = 0; e_rec = 0;
      m_ind1 = 0; m_ind2 = 0; m_pid = 0; m_guest = 0;
      for (int i = 0; i < NM; i++) begin m_best[i] = 0; m_bpid[i] = 0; end
   endtask

   task automatic model_step();
      logic first_now;
      int   sc;
      first_now = m_first;
      m_first = 0;
      sc = clip(m_cnt, 127);
      e_log = 0; e_reconf = 0; e_scram = 0; e_flip = 0; e_rec = 0;
      case (m_st)
         ST_INIT: begin
            m_mode = 0; m_flag = 0; m_cnt = 0;
            if (logOn) begin m_st = ST_SETUP; m_mux = 1; m_ten = 1; end
         end
         ST_SETUP: begin
            if (pwdPls) begin m_st = ST_LOGOUT; e_log = 1; end
            else if (loadPls) begin
               m_mode = (m_mode + 1) % NM;
               if (m_mode == 0) begin m_st = ST_TOPSCORE; m_flag = 0; end
            end else if (startPls) begin m_st = ST_GETWORD; e_reconf = 1; end
         end
         ST_GETWORD: begin
            if (startPls) m_st = ST_SETUP;
            else if (timeOut) begin m_st = ST_GAMEOVER; m_first = 1; end
            else if (pwdPls) begin m_st = ST_SWAP; e_scram = 1; end
         end
         ST_SWAP: begin
            m_ind1 = indIn1; m_ind2 = indIn2;
            if (startPls) m_st = ST_SETUP;
            else if (timeOut) begin m_st = ST_GAMEOVER; m_first = 1; end
            else if (isCorrect) m_st = ST_CORRECT;
            else if (loadPls) e_flip = 1;
         end
         ST_CORRECT: begin
            m_cnt++;
            m_st = ST_GETWORD;
         end
         ST_GAMEOVER: begin
            m_pid = pIDin; m_guest = isGuestIn;
            if (first_now && !isGuestIn && sc > m_best[m_mode]) begin
               m_best[m_mode] = sc; m_bpid[m_mode] = pIDin; e_rec = 1;
            end
            if (startPls) begin m_st = ST_SETUP; m_mode = 0; end
         end
         ST_LOGOUT: begin
            m_mux = 0; m_ten = 0; m_st = ST_INIT;
         end
         default: begin // ST_TOPSCORE
            if (startPls) m_flag = ~m_flag;
            else if (loadPls) begin
               m_mode = (m_mode + 1) % NM;
               if (m_mode == 0) begin m_st = ST_SETUP; m_flag = 0; end
            end
         end
      endcase
      if (m_st == ST_SETUP) m_cnt = 0;
   endtask

   always @(posedge clk) begin
      if (!rst) model_reset();
      else model_step();
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("state",         state_dbg,     m_st);
         chk("controlSig",    controlSig,    page(m_st, m_flag));
         chk("mode",          mode,          m_mode);
         chk("modeDisp",      modeDisp,      m_mode + 4);
         chk("score",         score,         clip(m_cnt, 127));
         chk("score_w3",      b_score,       clip(m_cnt, 7));
         chk("topScore",      topScore,      m_best[m_mode]);
         chk("topPid",        topPid,        m_bpid[m_mode]);
         chk("pIDout",        pIDout,        m_pid);
         chk("isGuestOut",    isGuestOut,    m_guest);
         chk("indOut1",       indOut1,       m_ind1);
         chk("indOut2",       indOut2,       m_ind2);
         chk("Mux_Ctrl",      Mux_Ctrl,      m_mux);
         chk("timerEn",       timerEn,       m_ten);
         chk("logOut",        logOut,        e_log);
         chk("timerReconfig", timerReconfig, e_reconf);
         chk("scramPls",      scramPls,      e_scram);
         chk("flipPls",       flipPls,       e_flip);
         chk("newRecord",     newRecord,     e_rec);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic apply(input logic [5:0] p);
      logOn = p[0]; pwdPls = p[1]; startPls = p[2];
      loadPls = p[3]; isCorrect = p[4]; timeOut = p[5];
      @(negedge clk);
   endtask

   // From SETUP: play a game with n correct words, end it by timeout and
   // return newRecord as seen after the game-over entry cycle.
   task automatic play_game(input int n, input logic g, input logic [2:0] pid, output logic rec);
      apply(P_START);
      apply(6'b0);
      for (int i = 0; i < n; i++) begin
         apply(P_PWD);
         apply(P_CORR);
         apply(6'b0);
      end
      isGuestIn = g;
      pIDin = pid;
      apply(P_TOUT);
      apply(6'b0);
      rec = newRecord;
      apply(6'b0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic rec;
      logic [5:0] p;
      rst = 1'b0;
      apply(6'b0);
      apply(6'b0);
      chk_en = 1'b1;
      rst = 1'b1;
      chk("reset_controlSig", controlSig, 0);
      chk("reset_score",      score,      0);
      chk("reset_Mux_Ctrl",   Mux_Ctrl,   0);

      // mode stepping and top-score browsing
      apply(P_LOGON);
      chk("logon_page", controlSig, 1);
      chk("logon_mux",  Mux_Ctrl,   1);
      apply(P_LOAD);  chk("load1_mode", mode, 1);
      apply(P_LOAD);  chk("load2_mode", mode, 2);  chk("load2_disp", modeDisp, 6);
      apply(P_LOAD);  chk("load3_page", controlSig, 4); chk("load3_mode", mode, 0);
      apply(P_START); chk("top_holder_page", controlSig, 5);
      apply(P_LOAD);  apply(P_LOAD); apply(P_LOAD);
      chk("browse_wrap_page", controlSig, 1);
      chk("browse_wrap_mode", mode, 0);

      // first record in mode 0
      indIn1 = 3'd2; indIn2 = 3'd6;
      play_game(3, 1'b0, 3'd5, rec);
      chk("g1_newRecord", rec, 1);
      chk("g1_score",     score, 3);
      chk("g1_page",      controlSig, 3);
      chk("g1_topScore",  topScore, 3);
      chk("g1_topPid",    topPid, 5);
      chk("g1_indOut1",   indOut1, 2);

      // record of 2 in mode 1, then a guest beating it
      apply(P_START); apply(P_LOAD);
      play_game(2, 1'b0, 3'd2, rec);
      chk("g2_newRecord", rec, 1);
      chk("g2_topScore",  topScore, 2);
      apply(P_START); apply(P_LOAD);
      play_game(6, 1'b1, 3'd4, rec);
      chk("guest_newRecord", rec, 0);
      chk("guest_score",     score, 6);
      chk("guest_topScore",  topScore, 2);
      chk("guest_topPid",    topPid, 2);

      // nine correct words: 7-bit score counts on, 3-bit score holds at 7
      apply(P_START);
      play_game(9, 1'b1, 3'd1, rec);
      chk("sat_score_w7", score, 9);
      chk("sat_score_w3", b_score, 7);

      // simultaneous timeout/correct/load in SWAP
      isGuestIn = 1'b0;
      apply(P_START); apply(P_START); apply(P_PWD); apply(P_CORR); apply(6'b0);
      apply(P_PWD);
      apply(P_TOUT | P_CORR | P_LOAD);
      chk("tie_state",   state_dbg, ST_GAMEOVER);
      chk("tie_flipPls", flipPls, 0);
      chk("tie_score",   score, 1);
      apply(6'b0);
      chk("tie_no_record", newRecord, 0);

      // logout
      apply(P_START);
      apply(P_PWD);
      chk("logout_pulse", logOut, 1);
      apply(6'b0);
      chk("logout_mux",     Mux_Ctrl, 0);
      chk("logout_timerEn", timerEn, 0);
      chk("logout_topScore_kept", topScore, 3);

      // reset in SWAP with score 5
      apply(P_LOGON); apply(P_START); apply(6'b0);
      for (int i = 0; i < 5; i++) begin apply(P_PWD); apply(P_CORR); apply(6'b0); end
      apply(P_PWD);
      chk("pre_reset_score", score, 5);
      rst = 1'b0;
      apply(6'b0);
      rst = 1'b1;
      chk("midreset_state",    state_dbg, ST_INIT);
      chk("midreset_score",    score, 0);
      chk("midreset_page",     controlSig, 0);
      chk("midreset_topScore", topScore, 0);

      // randomized phase
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 6; b++) p[b] = ($urandom_range(0, 4) == 0);
         pIDin     = 3'($urandom_range(0, 7));
         isGuestIn = ($urandom_range(0, 3) == 0);
         indIn1    = 3'($urandom_range(0, 7));
         indIn2    = 3'($urandom_range(0, 7));
         rst       = ($urandom_range(0, 299) != 0);
         apply(p);
      end
      rst = 1'b1;
      apply(6'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
